demux_iact: RTL

- Distributor for input-activation words; the inverse of the iact multiplexer.
- Takes one upstream iact stream: data a_i, valid b_i, stall c_o.
- Routes bursts of BURST_LEN words round-robin to O_COUNT downstream channels, starting from a selectable channel.
- Each downstream channel has a one-entry output register with its own stall input; one full round ends with a flush and a done pulse.

---
 rtl/demux_iact.sv | 127 ++++++++++++
 1 files changed

// File: rtl/demux_iact.sv
// demux_iact: distributes one iact stream round-robin, in bursts, to
// O_COUNT channels, each with a one-entry output register.
module demux_iact #(
  parameter int WIDTH     = 20,
  parameter int O_COUNT   = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [$clog2(O_COUNT)-1:0] start_sel_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic                       b_i,
  output logic                       c_o,
  output logic [WIDTH-1:0]           a_o [O_COUNT],
  output logic                       b_o [O_COUNT],
  input  logic                       c_i [O_COUNT],
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int SW = $clog2(O_COUNT);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [SW-1:0] LAST_CH = SW'(O_COUNT - 1);
  localparam logic [CW-1:0] LAST_W  = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t             state_q;
  logic [SW-1:0]      dest_q;
  logic [SW-1:0]      burst_q;
  logic [CW-1:0]      word_q;
  logic               done_q;
  logic [WIDTH-1:0]   data_q [O_COUNT];
  logic [WIDTH-1:0]   data_d [O_COUNT];
  logic [O_COUNT-1:0] vld_q;
  logic [O_COUNT-1:0] vld_d;
  logic [O_COUNT-1:0] load;
  logic               stall;
  logic               accept;

  // Only the current destination can back-pressure upstream.
  always_comb begin
    stall  = (state_q != RUN) | (vld_q[dest_q] & c_i[dest_q]);
    accept = b_i & ~stall;
  end

  always_comb begin
    load   = '0;
    vld_d  = vld_q;
    data_d = data_q;
    for (int k = 0; k < O_COUNT; k++) begin
      load[k] = accept && (dest_q == SW'(k))
                && (!vld_q[k] || !c_i[k]);
      data_d[k] = load[k] ? a_i : data_q[k];
      vld_d[k]  = load[k] | (vld_q[k] & c_i[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < O_COUNT; k++)
        data_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < O_COUNT; k++)
        data_q[k] <= data_d[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dest_q  <= '0;
      word_q  <= '0;
      burst_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            dest_q  <= (start_sel_i > LAST_CH) ? '0 : start_sel_i;
            word_q  <= '0;
            burst_q <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            word_q <= word_q + 1'b1;
            if (word_q == LAST_W) begin
              word_q  <= '0;
              dest_q  <= (dest_q == LAST_CH) ? '0 : dest_q + 1'b1;
              burst_q <= burst_q + 1'b1;
              if (burst_q == LAST_CH)
                state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (vld_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    c_o    = stall;
    busy_o = (state_q != IDLE);
    done_o = done_q;
    for (int k = 0; k < O_COUNT; k++) begin
      a_o[k] = data_q[k];
      b_o[k] = vld_q[k];
    end
  end

endmodule
